// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial front end for the 1011 sequence detector: WIDTH-bit words in, one bit per clk out.
// Define FEEDER_PARITY_EN to append an even-parity bit (state PARITY) after each word.
module serial_bit_feeder #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             stall,
  output logic             serial_out,
  output logic             bit_valid,
  output logic             frame_done
);

  localparam int unsigned    CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1
`ifdef FEEDER_PARITY_EN
    ,
    S_PARITY = 2'd2
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              serial_q, serial_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
`ifdef FEEDER_PARITY_EN
  logic              par_q, par_d;
`endif

  logic              final_s;
  logic              accept_s;
  logic              first_bit_s;
  logic              next_bit_s;
  logic [WIDTH-1:0]  load_rest_s;
  logic [WIDTH-1:0]  shift_adv_s;

  // The bit being presented is the last of its frame (parity bit when enabled).
`ifdef FEEDER_PARITY_EN
  assign final_s = (state_q == S_PARITY);
`else
  assign final_s = (state_q == S_SHIFT) && (cnt_q == CNT_ZERO);
`endif

  assign load_ready = rst && !stall && ((state_q == S_IDLE) || final_s);
  assign accept_s   = load_valid && load_ready;

  assign first_bit_s = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
  assign next_bit_s  = MSB_FIRST ? shift_q[WIDTH-1]   : shift_q[0];
  assign load_rest_s = MSB_FIRST ? {load_data[WIDTH-2:0], 1'b0} : {1'b0, load_data[WIDTH-1:1]};
  assign shift_adv_s = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0}   : {1'b0, shift_q[WIDTH-1:1]};

  // Next-state and next-output logic; stall freezes everything.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    serial_d = serial_q;
    valid_d  = valid_q;
    done_d   = done_q;
`ifdef FEEDER_PARITY_EN
    par_d    = par_q;
`endif
    if (stall) begin
      state_d = state_q;
    end else if (accept_s) begin
      state_d  = S_SHIFT;
      shift_d  = load_rest_s;
      cnt_d    = CNT_LAST;
      serial_d = first_bit_s;
      valid_d  = 1'b1;
      done_d   = 1'b0;
`ifdef FEEDER_PARITY_EN
      par_d    = ^load_data;
`endif
    end else begin
      case (state_q)
        S_SHIFT: begin
          if (cnt_q != CNT_ZERO) begin
            serial_d = next_bit_s;
            shift_d  = shift_adv_s;
            cnt_d    = cnt_q - CNT_ONE;
`ifdef FEEDER_PARITY_EN
            done_d   = 1'b0;
`else
            done_d   = (cnt_q == CNT_ONE);
`endif
          end else begin
`ifdef FEEDER_PARITY_EN
            state_d  = S_PARITY;
            serial_d = par_q;
            valid_d  = 1'b1;
            done_d   = 1'b1;
`else
            state_d  = S_IDLE;
            serial_d = IDLE_LEVEL;
            valid_d  = 1'b0;
            done_d   = 1'b0;
`endif
          end
        end
        default: begin
          state_d  = S_IDLE;
          cnt_d    = CNT_ZERO;
          serial_d = IDLE_LEVEL;
          valid_d  = 1'b0;
          done_d   = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      shift_q  <= {WIDTH{1'b0}};
      cnt_q    <= CNT_ZERO;
      serial_q <= IDLE_LEVEL;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
`ifdef FEEDER_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      serial_q <= serial_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
`ifdef FEEDER_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign serial_out = serial_q;
  assign bit_valid  = valid_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Self-checking bench for serial_bit_feeder: table-driven words plus stall, chaining and reset sequences.
// Honours FEEDER_PARITY_EN so the same bench covers both builds.
module tb_serial_bit_feeder;

`ifdef FEEDER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int FL = PAR ? 9 : 8;

  typedef struct packed { logic b; logic d; } exp_t;
  typedef struct { logic [7:0] data; logic [7:0] seq; logic par; } vec_t;

  logic       clk, rst, stall, load_valid, load_ready, serial_out, bit_valid, frame_done;
  logic [7:0] load_data;
  logic       lv2, rdy2, so2, bv2, fd2;
  logic [7:0] ld2;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  exp_t last_e;
  int   run_len = 0;
  int   last_run = 0;
  logic stall_prev = 1'b0;
  vec_t vecs[7];

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .stall(stall), .serial_out(serial_out),
    .bit_valid(bit_valid), .frame_done(frame_done)
  );

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .load_valid(lv2), .load_ready(rdy2),
    .load_data(ld2), .stall(stall), .serial_out(so2),
    .bit_valid(bv2), .frame_done(fd2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: a new bit follows every non-stalled edge; stalled edges must hold.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_bit_valid", bit_valid, 1'b0);
      chk("rst_load_ready", load_ready, 1'b0);
      run_len    = 0;
      stall_prev = 1'b0;
    end else if (bit_valid) begin
      run_len++;
      if (!stall_prev) begin
        chk("sb_has_entry", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          last_e = exp_q.pop_front();
          chk("sb_bit", serial_out, last_e.b);
          chk("sb_frame_done", frame_done, last_e.d);
        end
      end else begin
        chk("hold_bit", serial_out, last_e.b);
        chk("hold_frame_done", frame_done, last_e.d);
      end
      stall_prev = stall;
    end else begin
      if (run_len != 0) last_run = run_len;
      run_len = 0;
      chk("idle_level", serial_out, 1'b0);
      chk("idle_frame_done", frame_done, 1'b0);
      stall_prev = stall;
    end
  end

  // Offer a word, wait for the accept edge, then push its expected bit stream.
  task automatic push_word(input logic [7:0] d, input logic [7:0] seq, input logic par);
    bit   acc = 1'b0;
    bit   got;
    exp_t e;
    load_valid = 1'b1;
    load_data  = d;
    for (int k = 0; k < 40 && !acc; k++) begin
      #1 got = load_ready;
      @(posedge clk);
      acc = got;
    end
    #1;
    load_valid = 1'b0;
    load_data  = ~d;
    chk("accept", acc, 1'b1);
    if (acc) begin
      for (int i = 7; i >= 0; i--) begin
        e.b = seq[i];
        e.d = (i == 0) && !PAR;
        exp_q.push_back(e);
      end
      if (PAR) begin
        e.b = par;
        e.d = 1'b1;
        exp_q.push_back(e);
      end
      chk("first_bit_latency", bit_valid, 1'b1);
    end
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(posedge clk);
      #2 ok = (exp_q.size() == 0) && !bit_valid;
    end
    chk("drain", ok, 1'b1);
    @(negedge clk);
    #1;
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] lsb_seq;
    vecs[0] = '{data: 8'hB0, seq: 8'b1011_0000, par: 1'b1};
    vecs[1] = '{data: 8'hB4, seq: 8'b1011_0100, par: 1'b0};
    vecs[2] = '{data: 8'h0D, seq: 8'b0000_1101, par: 1'b1};
    vecs[3] = '{data: 8'hFF, seq: 8'b1111_1111, par: 1'b0};
    vecs[4] = '{data: 8'h00, seq: 8'b0000_0000, par: 1'b0};
    vecs[5] = '{data: 8'hA5, seq: 8'b1010_0101, par: 1'b0};
    vecs[6] = '{data: 8'h01, seq: 8'b0000_0001, par: 1'b1};

    rst = 1'b1; stall = 1'b0; load_valid = 1'b0; load_data = 8'h00; lv2 = 1'b0; ld2 = 8'h00;
    #1 rst = 1'b0;
    load_valid = 1'b1;
    #1;
    chk("reset_serial_out", serial_out, 1'b0);
    chk("reset_bit_valid", bit_valid, 1'b0);
    chk("reset_frame_done", frame_done, 1'b0);
    chk("reset_load_ready", load_ready, 1'b0);
    step();
    step();
    rst = 1'b1;
    load_valid = 1'b0;
    #1 chk("idle_load_ready", load_ready, 1'b1);
    step();

    // Single words, one per frame.
    foreach (vecs[v]) begin
      push_word(vecs[v].data, vecs[v].seq, vecs[v].par);
      wait_drain();
      chk("frame_length", last_run, FL);
    end

    // Back-to-back words stream with no gap.
    push_word(8'hB0, 8'b1011_0000, 1'b1);
    push_word(8'h0D, 8'b0000_1101, 1'b1);
    wait_drain();
    chk("chain_length", last_run, 2 * FL);

    // Stall for 3 cycles while the 3rd bit is presented.
    push_word(8'hB0, 8'b1011_0000, 1'b1);
    step();
    step();
    stall = 1'b1;
    repeat (3) step();
    stall = 1'b0;
    wait_drain();
    chk("stall_frame_length", last_run, FL + 3);

    // Stall on the final bit: frame_done holds, no accept, then chain the next word.
    push_word(8'h0D, 8'b0000_1101, 1'b1);
    repeat (FL - 1) step();
    stall = 1'b1;
    load_valid = 1'b1;
    load_data = 8'hFF;
    #1 chk("stall_final_ready", load_ready, 1'b0);
    step();
    chk("stall_final_ready_2", load_ready, 1'b0);
    step();
    stall = 1'b0;
    push_word(8'hFF, 8'b1111_1111, 1'b0);
    wait_drain();
    chk("stall_chain_length", last_run, 2 * FL + 2);

    // Stall with load_valid in IDLE: nothing accepted.
    stall = 1'b1;
    load_valid = 1'b1;
    load_data = 8'hAA;
    repeat (3) begin
      #1 chk("idle_stall_ready", load_ready, 1'b0);
      step();
    end
    chk("idle_stall_bit_valid", bit_valid, 1'b0);
    stall = 1'b0;
    load_valid = 1'b0;
    step();
    chk("idle_stall_no_start", bit_valid, 1'b0);

    // Reset on the 5th bit discards the word.
    push_word(8'hB0, 8'b1011_0000, 1'b1);
    repeat (4) step();
    rst = 1'b0;
    exp_q.delete();
    load_valid = 1'b1;
    #1;
    chk("midrst_bit_valid", bit_valid, 1'b0);
    chk("midrst_serial_out", serial_out, 1'b0);
    chk("midrst_frame_done", frame_done, 1'b0);
    chk("midrst_load_ready", load_ready, 1'b0);
    step();
    step();
    rst = 1'b1;
    load_valid = 1'b0;
    #1 chk("post_rst_bit_valid", bit_valid, 1'b0);
    step();
    push_word(8'hFF, 8'b1111_1111, 1'b0);
    wait_drain();
    chk("post_rst_frame_length", last_run, FL);

    // LSB-first instance.
    lsb_seq = 8'b1011_0000;
    lv2 = 1'b1;
    ld2 = 8'h0D;
    #1 chk("lsb_ready", rdy2, 1'b1);
    step();
    lv2 = 1'b0;
    ld2 = 8'hF2;
    for (int i = 7; i >= 0; i--) begin
      chk("lsb_bit", so2, lsb_seq[i]);
      chk("lsb_bit_valid", bv2, 1'b1);
      chk("lsb_frame_done", fd2, (i == 0) && !PAR);
      step();
    end
`ifdef FEEDER_PARITY_EN
    chk("lsb_parity_bit", so2, 1'b1);
    chk("lsb_parity_done", fd2, 1'b1);
    step();
`endif
    chk("lsb_idle", bv2, 1'b0);
    chk("lsb_idle_level", so2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
